// File: rtl/mux_pkg.sv
// Shared types and limits for the arb_mux_v2 channel multiplexer family.
// Pure declarations, no logic.
package mux_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  localparam int MAX_CH = 16;

endpackage

// File: rtl/rr_arbiter_v2.sv
// Combinational N-way arbiter: round-robin from ptr, or fixed lowest-index priority.
// Zero latency; grant depends only on req and ptr, never on payload.
module rr_arbiter_v2 import mux_pkg::*; #(
  parameter int        N    = 4,
  parameter arb_mode_e MODE = ARB_RR,
  localparam int       SW   = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] grant_idx
);

  logic [SW:0] base;
  logic [SW:0] idx;
  logic        found;

  // Fixed priority is just a round-robin search that always starts at 0.
  assign base = (MODE == ARB_FIXED) ? '0 : {1'b0, ptr};

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = base + (SW+1)'(k);
      if (idx >= (SW+1)'(N)) idx = idx - (SW+1)'(N);
      if (!found && req[idx[SW-1:0]]) begin
        found                 = 1'b1;
        grant[idx[SW-1:0]]    = 1'b1;
        grant_idx             = idx[SW-1:0];
      end
    end
  end

endmodule

// File: rtl/arb_mux_v2.sv
// N-to-1 arbitrated mux into a single-entry output register; 1-cycle latency, full throughput.
// Backpressure: a held word with out_ready low blocks every in_ready until it drains.
module arb_mux_v2 import mux_pkg::*; #(
  parameter int        WIDTH = 32,
  parameter int        N     = 4,
  parameter arb_mode_e MODE  = ARB_RR,
  localparam int       SW    = $clog2(N)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N-1:0]              in_valid,
  input  logic [N-1:0][WIDTH-1:0]   in_data,
  output logic [N-1:0]              in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SW-1:0]             out_sel,
  input  logic                      out_ready
);

  if (N < 2 || N > MAX_CH) begin : g_bad_n
    $error("arb_mux_v2: N out of range");
  end

  logic [N-1:0]  grant;
  logic [SW-1:0] grant_idx;
  logic [SW-1:0] ptr;
  logic          can_load;
  logic          in_xfer;

  rr_arbiter_v2 #(
    .N    (N),
    .MODE (MODE)
  ) u_arb (
    .req       (in_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign can_load = !out_valid || out_ready;
  // Gated by rst_n so nothing is accepted on a reset edge.
  assign in_ready = (rst_n && can_load) ? grant : '0;
  assign in_xfer  = |in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[grant_idx];
      out_sel   <= grant_idx;
      if (MODE == ARB_RR) begin
        ptr <= (grant_idx == SW'(N-1)) ? '0 : grant_idx + 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
